// File: rtl/fp_cmp_pipe.sv
// fp_cmp_pipe: pipelined IEEE-style compare / min / max / sign-manipulation unit.
// The result is computed combinationally from the operands and then carried through
// PIPE elastic valid/ready stages, so latency is PIPE cycles at full throughput.
// Optional feature macro: FP_CMP_PIPE_NAN_CHECK_EN. When defined, NaN operands make the
// compare unordered and MIN/MAX prefer the non-NaN operand. When undefined, NaNs are
// ordered as plain sign-magnitude bit patterns.
module fp_cmp_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int PIPE  = 2     // legal 1..4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               op,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     z,
    output logic                     gr,
    output logic                     ls,
    output logic                     eq,
    output logic                     unord
);

    localparam int W = 1 + EXP_W + MAN_W;

    // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
    localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0] POS_ZERO  = '0;
    localparam logic [W-1:0] NEG_ZERO  = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_CMP    = 3'd0,
        OP_MIN    = 3'd1,
        OP_MAX    = 3'd2,
        OP_ABS    = 3'd3,
        OP_NEG    = 3'd4,
        OP_CPYSGN = 3'd5,
        OP_RSV6   = 3'd6,
        OP_RSV7   = 3'd7
    } op_e;

    typedef struct packed {
        logic [W-1:0] z;
        logic         gr;
        logic         ls;
        logic         eq;
        logic         unord;
    } res_t;

    // Operand decode and the combinational result fed into stage 0.
    logic         a_sign, b_sign;
    logic [W-2:0] a_mag,  b_mag;
    logic         a_nan,  b_nan;
    logic         both_zero;
    logic         cmp_gt, cmp_lt, cmp_eq, cmp_un;
    res_t         res_c;

    // Pipeline state.
    logic [PIPE-1:0] valid_q, valid_d;
    logic [PIPE-1:0] load_en;
    res_t            data_q [PIPE];
    res_t            data_d [PIPE];

    // Classify operands: sign/magnitude split, zero detection and optional NaN detection.
    always_comb begin
        a_sign    = a[W-1];
        b_sign    = b[W-1];
        a_mag     = a[W-2:0];
        b_mag     = b[W-2:0];
        both_zero = (a_mag == '0) && (b_mag == '0);
`ifdef FP_CMP_PIPE_NAN_CHECK_EN
        a_nan = (&a[W-2 -: EXP_W]) && (|a[MAN_W-1:0]);
        b_nan = (&b[W-2 -: EXP_W]) && (|b[MAN_W-1:0]);
`else
        a_nan = 1'b0;
        b_nan = 1'b0;
`endif
    end

    // Sign-magnitude ordering; +0 and -0 are equal, any NaN makes the pair unordered.
    always_comb begin
        cmp_un = a_nan || b_nan;
        cmp_eq = both_zero || (a == b);
        if (a_sign == b_sign) begin
            // Same sign: larger magnitude wins for positives, loses for negatives.
            cmp_gt = a_sign ? (a_mag < b_mag) : (a_mag > b_mag);
            cmp_lt = a_sign ? (a_mag > b_mag) : (a_mag < b_mag);
        end else begin
            cmp_gt = !a_sign && !both_zero;
            cmp_lt =  a_sign && !both_zero;
        end
        if (cmp_un) begin
            cmp_gt = 1'b0;
            cmp_lt = 1'b0;
            cmp_eq = 1'b0;
        end
    end

    // Select the result word for the requested operation and bundle it with the flags.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it
        // unassigned -- otherwise synthesis infers a latch.
        res_c       = '0;
        res_c.gr    = cmp_gt;
        res_c.ls    = cmp_lt;
        res_c.eq    = cmp_eq;
        res_c.unord = cmp_un;
        case (op_e'(op))
            OP_CMP: res_c.z = '0;
            OP_MIN: begin
                if (cmp_un)
                    res_c.z = (a_nan && b_nan) ? CANON_NAN : (a_nan ? b : a);
                else if (both_zero && (a_sign != b_sign))
                    res_c.z = NEG_ZERO;
                else
                    res_c.z = (cmp_lt || cmp_eq) ? a : b;
            end
            OP_MAX: begin
                if (cmp_un)
                    res_c.z = (a_nan && b_nan) ? CANON_NAN : (a_nan ? b : a);
                else if (both_zero && (a_sign != b_sign))
                    res_c.z = POS_ZERO;
                else
                    res_c.z = (cmp_gt || cmp_eq) ? a : b;
            end
            OP_ABS:    res_c.z = {1'b0,    a[W-2:0]};
            OP_NEG:    res_c.z = {~a_sign, a[W-2:0]};
            OP_CPYSGN: res_c.z = {b_sign,  a[W-2:0]};
            default:   res_c.z = a;
        endcase
    end

    // Elastic handshake: a stage may load when it is empty or its content moves on,
    // which is evaluated from the output stage back towards the input.
    always_comb begin
        logic ok_chain;
        ok_chain = out_ready;
        load_en  = '0;
        for (int i = PIPE - 1; i >= 0; i--) begin
            load_en[i] = !valid_q[i] || ok_chain;
            ok_chain   = load_en[i];
        end
    end

    assign in_ready = !rst && load_en[0];

    // Next-state for each stage: take the upstream content when loading, else hold.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < PIPE; i++) begin
            data_d[i] = data_q[i];
        end
        if (load_en[0]) begin
            valid_d[0] = in_valid && in_ready;
            data_d[0]  = res_c;
        end
        for (int i = 1; i < PIPE; i++) begin
            if (load_en[i]) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples the
        // pre-edge value of its neighbours, independent of statement order.
        if (rst) begin
            valid_q <= '0;
            // NOTE: the data registers are reset too, not just the valid bits, because
            // z and the flags are required to read zero after reset.
            for (int i = 0; i < PIPE; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < PIPE; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = valid_q[PIPE-1] && !rst;
    assign z         = data_q[PIPE-1].z;
    assign gr        = data_q[PIPE-1].gr;
    assign ls        = data_q[PIPE-1].ls;
    assign eq        = data_q[PIPE-1].eq;
    assign unord     = data_q[PIPE-1].unord;

endmodule

// File: tb/tb_fp_cmp_pipe.sv
// tb_fp_cmp_pipe: directed and randomized checks of fp_cmp_pipe against a
// key-based reference model (sign-magnitude mapped onto signed integers).
`timescale 1ns/1ps
module tb_fp_cmp_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int PIPE  = 2;
    localparam int W     = 1 + EXP_W + MAN_W;

    localparam logic [2:0] OP_CMP = 3'd0, OP_MIN = 3'd1, OP_MAX = 3'd2, OP_ABS = 3'd3,
                           OP_NEG = 3'd4, OP_CPY = 3'd5, OP_R6  = 3'd6, OP_R7  = 3'd7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] z;
    logic         gr, ls, eq, unord;

    fp_cmp_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .PIPE(PIPE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .gr        (gr),
        .ls        (ls),
        .eq        (eq),
        .unord     (unord)
    );

    always #5 clk = ~clk;

    // f = {gr, ls, eq, unord}
    typedef struct packed {
        logic [W-1:0] z;
        logic [3:0]   f;
    } res_t;

    typedef struct {
        res_t r;
        int   acc;
    } item_t;

    item_t exp_q[$];
    int    checks   = 0;
    int    errors   = 0;
    int    cyc      = 0;
    int    recv     = 0;
    bit    lat_mode = 1'b0;
    bit    hold_valid = 1'b0;
    bit    accepted = 1'b0;
    bit    saw_drop = 1'b0;
    res_t  hold_val;
    res_t  cur_exp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic is_nan(input logic [W-1:0] x);
`ifdef FP_CMP_PIPE_NAN_CHECK_EN
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e = x[W-2 -: EXP_W];
        m = x[MAN_W-1:0];
        return (e == {EXP_W{1'b1}}) && (m != '0);
`else
        return (x === 'x);
`endif
    endfunction

    // Reference: order operands by a signed integer key (+0 and -0 both map to 0).
    function automatic res_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        res_t         r;
        longint       mx, my, kx, ky;
        logic         nx, ny, un;
        logic [W-1:0] canon;
        mx = longint'({1'b0, x[W-2:0]});
        my = longint'({1'b0, y[W-2:0]});
        kx = x[W-1] ? -mx : mx;
        ky = y[W-1] ? -my : my;
        nx = is_nan(x);
        ny = is_nan(y);
        un = nx || ny;
        canon = '0;
        canon[W-2 -: EXP_W] = '1;
        canon[MAN_W-1] = 1'b1;
        r.f = un ? 4'b0001 : {kx > ky, kx < ky, kx == ky, 1'b0};
        case (o)
            OP_CMP: r.z = '0;
            OP_MIN, OP_MAX: begin
                if (un)                              r.z = (nx && ny) ? canon : (nx ? y : x);
                else if (kx == 0 && ky == 0 && x != y) r.z = (o == OP_MIN) ? {1'b1, {(W-1){1'b0}}} : '0;
                else if (kx == ky)                   r.z = x;
                else if (o == OP_MIN)                r.z = (kx < ky) ? x : y;
                else                                 r.z = (kx > ky) ? x : y;
            end
            OP_ABS: r.z = {1'b0, x[W-2:0]};
            OP_NEG: r.z = {~x[W-1], x[W-2:0]};
            OP_CPY: r.z = {y[W-1], x[W-2:0]};
            default: r.z = x;
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] rand_opnd(input logic [W-1:0] other);
        logic [W-1:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r = 32'h0000_0000;
            1: r = 32'h8000_0000;
            2: r = other;
            3: r = other ^ 32'h8000_0000;
            4: r = r | 32'h7F80_0001;
            5: r = (r & 32'h8000_0000) | 32'h7F80_0000;
            default: ;
        endcase
        return r;
    endfunction

    // One clock cycle: drive inputs, sample outputs 1ns later, score both handshakes.
    task automatic cycle(input logic v, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic ordy);
        res_t  obs;
        item_t it;
        in_valid  = v;
        op        = o;
        a         = x;
        b         = y;
        out_ready = ordy;
        #1;
        obs = {z, gr, ls, eq, unord};
        accepted = 1'b0;
        if (rst) begin
            check("rst_in_ready",  64'(in_ready),  64'd0);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_hold",  64'(obs), 64'(hold_val));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    it = exp_q.pop_front();
                    check("result_z",     64'(z),     64'(it.r.z));
                    check("result_flags", 64'(obs.f), 64'(it.r.f));
                    if (lat_mode) check("latency", 64'(cyc - it.acc), 64'(PIPE));
                    recv++;
                end
            end
            hold_valid = out_valid && !out_ready;
            hold_val   = obs;
            if (v && in_ready) begin
                it.r   = cur_exp;
                it.acc = cyc;
                exp_q.push_back(it);
                accepted = 1'b1;
            end
            if (v && !in_ready) saw_drop = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, OP_CMP, '0, '0, 1'b1);
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && exp_q.size() > 0; k++) idle(1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        exp_q.delete();
        idle(n);
        check("rst_outputs_zero", 64'({z, gr, ls, eq, unord}), 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("in_ready_after_rst", 64'(in_ready), 64'd1);
    endtask

    // Offer one operation until accepted, with an explicit expected result.
    task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input res_t e);
        int k;
        cur_exp = e;
        k = 0;
        do begin
            cycle(1'b1, o, x, y, 1'b1);
            k++;
        end while (!accepted && k < 50);
        if (!accepted) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic directed(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] ez, input logic [3:0] ef);
        send(o, x, y, '{z: ez, f: ef});
        drain();
    endtask

    logic [2:0]   s_op [8];
    logic [W-1:0] s_a  [8];
    logic [W-1:0] s_b  [8];

    initial begin
        int base, sent, idx;
        logic [W-1:0] ra, rb;
        logic [2:0]   ro;

        @(posedge clk);
        #1;
        do_reset(3);

        // Directed vectors with constant expectations, latency checked.
        lat_mode = 1'b1;
        directed(OP_CMP, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0000, 4'b0100);
        directed(OP_MIN, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 4'b0010);
        directed(OP_MAX, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0010);
        directed(OP_MIN, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 4'b0010);
        directed(OP_MAX, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0010);
        directed(OP_NEG, 32'h3F80_0000, 32'h0000_0000, 32'hBF80_0000, 4'b1000);
        directed(OP_ABS, 32'hC000_0000, 32'h0000_0000, 32'h4000_0000, 4'b0100);
        directed(OP_CPY, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 4'b1000);
        directed(OP_R6,  32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 4'b0010);
        directed(OP_R7,  32'hC000_0000, 32'hBF80_0000, 32'hC000_0000, 4'b0100);
        directed(OP_MIN, 32'hC000_0000, 32'hBF80_0000, 32'hC000_0000, 4'b0100);
`ifdef FP_CMP_PIPE_NAN_CHECK_EN
        directed(OP_MAX, 32'h7FC0_0000, 32'hBF80_0000, 32'hBF80_0000, 4'b0001);
        directed(OP_MIN, 32'h3F80_0000, 32'hFFC0_0001, 32'h3F80_0000, 4'b0001);
        directed(OP_MAX, 32'h7FC0_0000, 32'hFF80_0001, 32'h7FC0_0000, 4'b0001);
        directed(OP_CMP, 32'h7F80_0001, 32'h7F80_0001, 32'h0000_0000, 4'b0001);
`else
        directed(OP_MAX, 32'h7FC0_0000, 32'hBF80_0000, 32'h7FC0_0000, 4'b1000);
        directed(OP_CMP, 32'h7F80_0001, 32'h7F80_0000, 32'h0000_0000, 4'b1000);
        directed(OP_MIN, 32'hFFC0_0000, 32'hFF80_0000, 32'hFFC0_0000, 4'b0100);
`endif

        // Full-throughput stream: every offer must be taken at once (in and out together).
        for (int i = 0; i < 20; i++) begin
            ra = rand_opnd($urandom);
            rb = rand_opnd(ra);
            ro = 3'($urandom_range(0, 7));
            cur_exp = model(ro, ra, rb);
            cycle(1'b1, ro, ra, rb, 1'b1);
            check("full_tput_accept", 64'(accepted), 64'd1);
        end
        drain();

        // Eight back-to-back ops with the output stalled in cycles 3..6.
        lat_mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_a[i]  = rand_opnd($urandom);
            s_b[i]  = rand_opnd(s_a[i]);
            s_op[i] = 3'($urandom_range(0, 7));
        end
        saw_drop = 1'b0;
        base = recv;
        sent = 0;
        for (int k = 0; k < 60 && recv < base + 8; k++) begin
            idx = (sent < 8) ? sent : 7;
            cur_exp = model(s_op[idx], s_a[idx], s_b[idx]);
            cycle(sent < 8, s_op[idx], s_a[idx], s_b[idx], !(k >= 3 && k <= 6));
            if (accepted) sent++;
        end
        check("stream_count",   64'(recv - base), 64'd8);
        check("stream_backpressure", 64'(saw_drop), 64'd1);
        drain();

        // Reset with two results in flight: they vanish, the next input comes out alone.
        lat_mode = 1'b1;
        ra = 32'h3F80_0000;
        rb = 32'h4000_0000;
        send(OP_MAX, ra, rb, model(OP_MAX, ra, rb));
        send(OP_MIN, ra, rb, model(OP_MIN, ra, rb));
        do_reset(1);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            check("post_rst_quiet", 64'(out_valid), 64'd0);
        end
        base = recv;
        send(OP_NEG, ra, rb, '{z: 32'hBF80_0000, f: 4'b0100});
        drain();
        idle(4);
        check("post_rst_one_result", 64'(recv - base), 64'd1);

        // Random traffic with random input gaps and output backpressure.
        lat_mode = 1'b0;
        for (int k = 0; k < 400; k++) begin
            ra = rand_opnd($urandom);
            rb = rand_opnd(ra);
            ro = 3'($urandom_range(0, 7));
            cur_exp = model(ro, ra, rb);
            cycle($urandom_range(0, 3) != 0, ro, ra, rb, $urandom_range(0, 3) != 0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_cmp_pipe.md
FP_CMP_PIPE -- requirements
Module: fp_cmp_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23, meaning mantissa field width; W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have parameter PIPE, default 2, legal 1..4, meaning pipeline stage count.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock.
REQ-005 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 The block SHALL have ports in_valid input 1 and in_ready output 1, the request handshake.
REQ-007 The block SHALL have port op  input  3  operation select.
REQ-008 The block SHALL have ports a and b, input, W each, IEEE-style operands {sign, exp, man}.
REQ-009 The block SHALL have ports out_valid output 1 and out_ready input 1, the result handshake.
REQ-010 The block SHALL have port z  output  W  result.
REQ-011 The block SHALL have ports gr, ls, eq, unord, each output 1, the a-vs-b compare flags.

Function
REQ-012 Transfers SHALL occur only on clk edges where valid and ready are both high, on either side.
REQ-013 Ops SHALL be: 0 CMP (z=0); 1 MIN; 2 MAX; 3 ABS (z=a, sign cleared); 4 NEG (z=a, sign inverted); 5 CPYSGN (a magnitude, b sign); 6,7 reserved (z=a).
REQ-014 Flags SHALL be computed for every op: gr = a>b, ls = a<b, eq = a==b; exactly one is high unless unord=1, in which case all three are 0.
REQ-015 Ordering SHALL be sign-magnitude; +0 and -0 (all-zero exp and man) SHALL compare equal.
REQ-016 MIN/MAX on equal operands SHALL return a, except (+0,-0) in either order: MIN gives -0 and MAX gives +0.
REQ-017 Latency SHALL be exactly PIPE cycles from accepted input to out_valid when out_ready is held high; throughput SHALL be one result per cycle.
REQ-018 The pipeline SHALL be elastic: a stage advances when the next stage is empty or advancing; in_ready = stage-0 empty or advancing.
REQ-019 While out_valid=1 and out_ready=0, z and the flags SHALL hold stable; no result SHALL be dropped or duplicated.
REQ-020 Results SHALL leave in acceptance order.
REQ-021 An input and an output transfer in the same cycle with the pipeline full SHALL both complete without a bubble.

Reset
REQ-022 While rst=1, all stage-valid bits, out_valid and in_ready SHALL be 0; z=0 and gr=ls=eq=unord=0 on the next edge.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight results; the first accepted input after reset SHALL appear PIPE cycles later.
REQ-024 in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-025 Macro FP_CMP_PIPE_NAN_CHECK_EN SHALL control NaN handling (NaN: exp all ones, man nonzero).
REQ-026 With FP_CMP_PIPE_NAN_CHECK_EN defined: any NaN operand sets unord=1; MIN/MAX return the non-NaN operand; if both are NaN they return canonical NaN (sign 0, exp all ones, man MSB 1, rest 0).
REQ-027 Without FP_CMP_PIPE_NAN_CHECK_EN: unord SHALL be tied to 0 and NaNs ordered as plain sign-magnitude patterns.

Verification (defaults EXP_W=8, MAN_W=23, PIPE=2)
REQ-028 CMP a=0x3F800000, b=0x40000000, out_ready=1 -> out_valid 2 cycles later, z=0, ls=1, gr=eq=unord=0.
REQ-029 MIN a=0x00000000, b=0x80000000 -> z=0x80000000, eq=1; MAX same operands -> z=0x00000000.
REQ-030 NAN_CHECK_EN defined, MAX a=0x7FC00000, b=0xBF800000 -> z=0xBF800000, unord=1, gr=ls=eq=0; both NaN -> z=0x7FC00000.
REQ-031 Back-to-back stream of 8 ops with out_ready=0 for cycles 3-6 -> in_ready drops when full; all 8 results arrive in order with no loss; z held stable during the stall.
REQ-032 rst pulsed 1 cycle after 2 inputs accepted -> out_valid stays 0; the next input yields exactly one result 2 cycles after acceptance.
REQ-033 NEG a=0x3F800000 -> z=0xBF800000; ABS a=0xC0000000 -> z=0x40000000; CPYSGN a=0x40000000, b=0x80000000 -> z=0xC0000000.
